// File: rtl/counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_sequencer                                            |
// | Description : Command-driven controller for the up/down counter block.     |
// |               Accepts run commands (direction, step count, optional clear) |
// |               over a valid/ready handshake and drives the counter's        |
// |               enable, direction and clear lines for exactly the commanded  |
// |               number of cycles, then pulses done.                          |
// | Options     : BOUND_STOP_EN - stop a run when the counter reaches its      |
// |               bound (all-ones going up, zero going down) instead of        |
// |               letting it wrap; reported through saturated.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module counter_sequencer #(
  parameter int CNT_W = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_up,
  input  logic             cmd_clr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [CNT_W-1:0] count_in,
  output logic             cnt_enable,
  output logic             cnt_up,
  output logic             cnt_clear,
  output logic             busy,
  output logic [LEN_W-1:0] steps_left,
  output logic             done,
  output logic             aborted,
  output logic             saturated
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;
  logic   at_bound;
  logic   handshake;

`ifdef BOUND_STOP_EN
  // Counter sits on the bound in the current direction; one more step would wrap.
  assign at_bound = cnt_up ? (count_in == {CNT_W{1'b1}}) : (count_in == {CNT_W{1'b0}});
`else
  // Counter wraps freely; its value is not needed.
  logic unused_count_in;
  assign unused_count_in = ^count_in;
  assign at_bound        = 1'b0;
  assign saturated       = 1'b0;
`endif

  // Ready only while idle and out of reset, so a command can never be taken under reset.
  assign cmd_ready = rst & (state == S_IDLE);
  assign handshake = cmd_valid & cmd_ready;

  // Enable is held off in the very cycle an abort or bound hit is seen, so no extra step slips through.
  assign cnt_enable = (state == S_RUN) & ~abort & ~at_bound;

  // Single FSM: state, run bookkeeping and the registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      steps_left <= '0;
      cnt_up     <= 1'b1;
      cnt_clear  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
`ifdef BOUND_STOP_EN
      saturated  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (handshake) begin
            cnt_up     <= cmd_up;
            steps_left <= cmd_len;
            aborted    <= 1'b0;
`ifdef BOUND_STOP_EN
            saturated  <= 1'b0;
`endif
            busy       <= 1'b1;
            if (cmd_clr) begin
              state     <= S_CLEAR;
              cnt_clear <= 1'b1;
            end else if (cmd_len != '0) begin
              state <= S_RUN;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          cnt_clear <= 1'b0;
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (steps_left != '0) begin
            state <= S_RUN;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_RUN: begin
          if (abort) begin
            // Abort wins over a simultaneous bound hit; remainder is kept.
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (at_bound) begin
            state     <= S_DONE;
            done      <= 1'b1;
`ifdef BOUND_STOP_EN
            saturated <= 1'b1;
`endif
          end else begin
            steps_left <= steps_left - LEN_W'(1);
            if (steps_left == LEN_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // One-cycle done pulse, then back to idle; this also guarantees an idle gap.
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          cnt_clear <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
